// File: rtl/obi_sram_sbr.sv
// OBI subordinate SRAM: accepts one request per cycle and returns responses in order through a small queue.
// Latency 1 + WAIT_CYCLES to rvalid; grant drops while the queue is full, obi_rready_i holds the head.
module obi_sram_sbr #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned DEPTH           = 256,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned WAIT_CYCLES     = 0
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    obi_req_i,
   output logic                    obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
   input  logic                    obi_we_i,
   input  logic [DATA_WIDTH/8-1:0] obi_be_i,
   input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
   output logic                    obi_rvalid_o,
   input  logic                    obi_rready_i,
   output logic [DATA_WIDTH-1:0]   obi_rdata_o,
   output logic                    obi_err_o,
   output logic                    busy_o
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned OFS   = $clog2(BYTES);
   localparam int unsigned IDXW  = $clog2(DEPTH);
   localparam int unsigned PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_VALID} state_t;

   logic [DATA_WIDTH-1:0] mem      [DEPTH];
   logic [DATA_WIDTH-1:0] fifo_dat [MAX_OUTSTANDING];
   logic                  fifo_err [MAX_OUTSTANDING];

   state_t                state, state_nxt;
   logic [3:0]            wait_cnt, wait_cnt_nxt;
   logic [CW-1:0]         count, count_nxt;
   logic [PW-1:0]         wptr, rptr;
   logic                  push, pop, oor;
   logic [IDXW-1:0]       idx;
   logic [DATA_WIDTH-1:0] rsp_dat;
   logic [OFS-1:0]        unused_lsb;

   // Byte offset inside a word carries no meaning for a word-wide SRAM.
   assign unused_lsb = obi_addr_i[OFS-1:0];
   assign idx        = obi_addr_i[OFS +: IDXW];
   assign oor        = |obi_addr_i[ADDR_WIDTH-1:OFS+IDXW];

   // Grant depends only on registered occupancy, never on obi_rready_i.
   assign obi_gnt_o = reset_ni && obi_req_i && (count < CW'(MAX_OUTSTANDING));
   assign push      = obi_req_i && obi_gnt_o;
   assign pop       = (state == S_VALID) && obi_rready_i;
   assign rsp_dat   = (obi_we_i || oor) ? '0 : mem[idx];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      count_nxt    = count + CW'(push) - CW'(pop);
      case (state)
         S_EMPTY: begin
            if (push) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_VALID;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = 4'(WAIT_CYCLES);
               end
            end
         end
         S_WAIT: begin
            if (wait_cnt <= 4'd1) begin
               state_nxt    = S_VALID;
               wait_cnt_nxt = '0;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         S_VALID: begin
            if (pop) begin
               if (count_nxt == '0) begin
                  state_nxt = S_EMPTY;
               end else if (WAIT_CYCLES == 0) begin
                  state_nxt = S_VALID;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = 4'(WAIT_CYCLES);
               end
            end
         end
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state    <= S_EMPTY;
         wait_cnt <= '0;
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         count    <= count_nxt;
         if (push) wptr <= ptr_inc(wptr);
         if (pop)  rptr <= ptr_inc(rptr);
      end
   end

   // Push never targets the head slot: it needs count < MAX_OUTSTANDING.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_dat[wptr] <= rsp_dat;
         fifo_err[wptr] <= oor;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && obi_we_i && !oor) begin
         for (int i = 0; i < BYTES; i++) begin
            if (obi_be_i[i]) mem[idx][i*8 +: 8] <= obi_wdata_i[i*8 +: 8];
         end
      end
   end

   assign obi_rvalid_o = (state == S_VALID);
   assign obi_rdata_o  = obi_rvalid_o ? fifo_dat[rptr] : '0;
   assign obi_err_o    = obi_rvalid_o && fifo_err[rptr];
   assign busy_o       = (count != '0);

endmodule

// File: doc/obi_sram_sbr.md
OBI_SRAM_SBR -- requirements
Module: obi_sram_sbr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width (32 or 64).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (32 or 64).
REQ-003 SHALL have parameter DEPTH, default 256, number of SRAM words (power of two, >= 2).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, response-queue depth (1..8).
REQ-005 SHALL have parameter WAIT_CYCLES, default 0, extra latency per response (0..15).
REQ-006 SHALL have port clk_i, input, 1, clock. All logic is on the rising edge.
REQ-007 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port obi_req_i, input, 1, A-channel request.
REQ-009 SHALL have port obi_gnt_o, output, 1, A-channel grant.
REQ-010 SHALL have port obi_addr_i, input, ADDR_WIDTH, byte address.
REQ-011 SHALL have port obi_we_i, input, 1, 1 = write, 0 = read.
REQ-012 SHALL have port obi_be_i, input, DATA_WIDTH/8, byte enables.
REQ-013 SHALL have port obi_wdata_i, input, DATA_WIDTH, write data.
REQ-014 SHALL have port obi_rvalid_o, output, 1, R-channel valid.
REQ-015 SHALL have port obi_rready_i, input, 1, R-channel ready.
REQ-016 SHALL have port obi_rdata_o, output, DATA_WIDTH, read data.
REQ-017 SHALL have port obi_err_o, output, 1, error response.
REQ-018 SHALL have port busy_o, output, 1, 1 while any response is outstanding.

Function
REQ-019 SHALL accept a transaction on a clock edge where obi_req_i && obi_gnt_o.
- obi_gnt_o = obi_req_i && (count < MAX_OUTSTANDING).
- count is the number of queued, unreturned responses.
- No combinational path from obi_rready_i to obi_gnt_o.
REQ-020 SHALL form the word index as obi_addr_i[OFS +: log2(DEPTH)], where OFS = log2(DATA_WIDTH/8).
- Low OFS bits are ignored.
REQ-021 SHALL flag an access out of range when obi_addr_i >= DEPTH*DATA_WIDTH/8.
- Out-of-range write: no memory update.
- Out-of-range read or write: response rdata = 0, err = 1.
REQ-022 SHALL apply an in-range write at its acceptance edge.
- Only lanes with obi_be_i[i] = 1 are updated.
- Response: rdata = 0, err = 0.
REQ-023 SHALL sample in-range read data at the acceptance edge.
- Data from a write accepted on an earlier edge is visible.
- obi_be_i is ignored for reads; the full word is returned.
REQ-024 SHALL push {rdata, err} into an in-order FIFO of MAX_OUTSTANDING entries at acceptance.
REQ-025 SHALL control the FIFO head with FSM EMPTY / WAIT / VALID.
- EMPTY -> WAIT on a push, loading wait_cnt = WAIT_CYCLES.
- WAIT decrements wait_cnt; moves to VALID once wait_cnt = 0.
- With WAIT_CYCLES = 0, WAIT lasts zero cycles: EMPTY -> VALID directly.
- VALID with obi_rready_i = 1 pops the head, then:
  - EMPTY if no entries remain;
  - otherwise WAIT, reloading wait_cnt.
REQ-026 SHALL drive obi_rvalid_o = 1 only in state VALID.
- obi_rdata_o / obi_err_o show the head entry while valid and are 0 otherwise.
- Minimum latency: rvalid on the cycle after acceptance + WAIT_CYCLES.
REQ-027 SHALL keep obi_rvalid_o, obi_rdata_o and obi_err_o stable while obi_rvalid_o && !obi_rready_i.
REQ-028 SHALL handle a simultaneous push and pop on one edge as count unchanged, FIFO order preserved.
REQ-029 SHALL wrap FIFO read/write pointers modulo MAX_OUTSTANDING.
REQ-030 SHALL drive busy_o = (count != 0).

Reset
REQ-031 SHALL, on reset_ni = 0, immediately clear the following:
- count, FIFO pointers and wait_cnt;
- FSM to EMPTY;
- obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o and busy_o to 0.
REQ-032 SHALL discard in-flight responses on reset mid-operation; SRAM contents are not reset and are undefined after power-up.

Verification (DATA_WIDTH = 32, DEPTH = 256, MAX_OUTSTANDING = 2 unless stated)
REQ-033 SHALL cover:
- Write 0xDEADBEEF to 0x10 with be = 0xF, then read 0x10.
- Required: write response err = 0; read rdata = 0xDEADBEEF one cycle after grant.
REQ-034 SHALL cover:
- Write 0x11223344 to 0x20 with be = 0xF, then write 0xAABBCCDD with be = 0x5, then read 0x20.
- Required: read rdata = 0x11BB33DD.
REQ-035 SHALL cover:
- Read address 0x400 (= DEPTH*4).
- Required: err = 1, rdata = 0, memory unchanged.
REQ-036 SHALL cover:
- Hold obi_rready_i = 0 and issue 3 back-to-back reads.
- Required: gnt = 1 for the first two only; then count = 2, busy_o = 1, rvalid held with stable data.
- After rready rises: responses return in order; the third read is granted.
REQ-037 SHALL cover:
- WAIT_CYCLES = 3, single read.
- Required: rvalid on the 4th cycle after acceptance.
REQ-038 SHALL cover:
- Assert reset_ni = 0 while 2 responses are pending.
- Required: rvalid and busy_o go 0 asynchronously; after release, a new read completes normally.
